// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues one ROM read per cycle, buffers responses in a 2-entry queue.
// Latency: issue in cycle N, ROM data in N+1, inst_valid in N+2; redirect in N gives the new target valid in N+3.
// Backpressure: issue is throttled so reads in flight plus queued never exceed 2; stalls while inst_ready is low.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   rom_addr, rom_ready          ROM read address (always pc) and read enable
//   rom_dout, rom_valid          ROM read data and strobe, one cycle after issue
//   redirect, redirect_pc        flush and restart fetch at redirect_pc
//   halt                         level; suppresses new reads only
//   inst, inst_pc                head of queue
//   inst_valid, inst_ready       decoder handshake
module ifetch #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 12,
   parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [AWIDTH-1:0] rom_addr,
   output logic              rom_ready,
   input  logic [DWIDTH-1:0] rom_dout,
   input  logic              rom_valid,
   input  logic              redirect,
   input  logic [AWIDTH-1:0] redirect_pc,
   input  logic              halt,
   output logic [DWIDTH-1:0] inst,
   output logic [AWIDTH-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready
);

   logic [AWIDTH-1:0] pc;
   logic              inflight;
   logic [AWIDTH-1:0] inflight_pc;
   logic              squash;

   // queue: head entry drives the outputs, tail holds the second entry
   logic [DWIDTH-1:0] head_inst, tail_inst;
   logic [AWIDTH-1:0] head_pc, tail_pc;
   logic [1:0]        count;

   logic       pop;
   logic       push;
   logic [2:0] free;

   assign inst_valid = (count != 2'd0);
   assign inst       = head_inst;
   assign inst_pc    = head_pc;
   assign rom_addr   = pc;

   assign pop  = inst_valid & inst_ready;
   assign push = rom_valid & inflight & ~squash;

   // slots not yet claimed by a queued entry or a read in flight; a pop this
   // cycle frees its slot in time for a read issued now to land next cycle
   assign free = 3'd2 - {1'b0, count} - {2'b0, inflight} + {2'b0, pop};

   // rst_n gates the enable so no read leaks out while reset is held
   assign rom_ready = rst_n & ~halt & ~redirect & (free != 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         squash      <= 1'b0;
         count       <= 2'd0;
         head_inst   <= '0;
         head_pc     <= '0;
         tail_inst   <= '0;
         tail_pc     <= '0;
      end else begin
         squash   <= 1'b0;
         inflight <= rom_ready;
         if (rom_ready) begin
            inflight_pc <= pc;
            pc          <= pc + {{(AWIDTH-1){1'b0}}, 1'b1};
         end
         if (redirect) begin
            // rom_ready is low here, so the pc update above never fires
            pc     <= redirect_pc;
            count  <= 2'd0;
            squash <= inflight;
         end else if (push && !pop) begin
            if (count == 2'd0) begin
               head_inst <= rom_dout;
               head_pc   <= inflight_pc;
            end else begin
               tail_inst <= rom_dout;
               tail_pc   <= inflight_pc;
            end
            count <= count + 2'd1;
         end else if (pop && !push) begin
            head_inst <= tail_inst;
            head_pc   <= tail_pc;
            count     <= count - 2'd1;
         end else if (push && pop) begin
            if (count == 2'd1) begin
               head_inst <= rom_dout;
               head_pc   <= inflight_pc;
            end else begin
               head_inst <= tail_inst;
               head_pc   <= tail_pc;
               tail_inst <= rom_dout;
               tail_pc   <= inflight_pc;
            end
         end
      end
   end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

   logic        clk;
   logic        rst_n, rst_n_w;
   logic [11:0] rom_addr, w_rom_addr;
   logic        rom_ready, w_rom_ready;
   logic [15:0] rom_dout, w_rom_dout;
   logic        rom_valid, w_rom_valid;
   logic        redirect;
   logic [11:0] redirect_pc;
   logic        halt;
   logic [15:0] inst, w_inst;
   logic [11:0] inst_pc, w_inst_pc;
   logic        inst_valid, w_inst_valid;
   logic        inst_ready;

   int total = 0;
   int bad   = 0;

   ifetch #(.DWIDTH(16), .AWIDTH(12), .RESET_PC(12'h000)) dut (
      .clk(clk), .rst_n(rst_n),
      .rom_addr(rom_addr), .rom_ready(rom_ready),
      .rom_dout(rom_dout), .rom_valid(rom_valid),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
   );

   // second instance only for the PC wrap-around case
   ifetch #(.DWIDTH(16), .AWIDTH(12), .RESET_PC(12'hFFE)) dut_wrap (
      .clk(clk), .rst_n(rst_n_w),
      .rom_addr(w_rom_addr), .rom_ready(w_rom_ready),
      .rom_dout(w_rom_dout), .rom_valid(w_rom_valid),
      .redirect(1'b0), .redirect_pc(12'h000), .halt(1'b0),
      .inst(w_inst), .inst_pc(w_inst_pc), .inst_valid(w_inst_valid), .inst_ready(1'b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: mem[a] = a + 0x100
   function automatic logic [15:0] romf(input logic [11:0] a);
      return {4'h0, a} + 16'h0100;
   endfunction

   // ROM with one-cycle read latency
   always @(posedge clk) begin
      rom_valid   <= rom_ready;
      rom_dout    <= rom_ready ? romf(rom_addr) : 16'h0000;
      w_rom_valid <= w_rom_ready;
      w_rom_dout  <= w_rom_ready ? romf(w_rom_addr) : 16'h0000;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- stream model and per-cycle compare ----------------
   // Delivered instructions must form a sequential PC run starting at the
   // reset or redirect target; issued addresses likewise; no more than two
   // reads may be issued and not yet accepted; a stalled head must hold.
   logic [11:0] exp_pc, issue_pc;
   int          pending;
   logic        prev_stall;
   logic [15:0] prev_inst;
   logic [11:0] prev_pc;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_pc     = 12'h000;
         issue_pc   = 12'h000;
         pending    = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", {31'b0, inst_valid}, 32'd1);
            chk("hold_inst", {16'b0, inst}, {16'b0, prev_inst});
            chk("hold_pc", {20'b0, inst_pc}, {20'b0, prev_pc});
         end
         if (inst_valid && inst_ready) begin
            chk("stream_pc", {20'b0, inst_pc}, {20'b0, exp_pc});
            chk("stream_inst", {16'b0, inst}, {16'b0, romf(exp_pc)});
            exp_pc  = exp_pc + 12'd1;
            pending = pending - 1;
         end
         if (rom_ready) begin
            chk("issue_addr", {20'b0, rom_addr}, {20'b0, issue_pc});
            issue_pc = issue_pc + 12'd1;
            pending  = pending + 1;
         end
         if (redirect) begin
            exp_pc   = redirect_pc;
            issue_pc = redirect_pc;
            pending  = 0;
         end
         chk("pending_le2", {31'b0, (pending <= 2)}, 32'd1);
         prev_stall = inst_valid & ~inst_ready & ~redirect;
         prev_inst  = inst;
         prev_pc    = inst_pc;
      end
   end

   // ---------------- directed timeline ----------------
   task automatic nc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      #3;
   endtask

   task automatic chk_head(input string name, input logic [11:0] pc);
      chk({name, "_valid"}, {31'b0, inst_valid}, 32'd1);
      chk({name, "_pc"}, {20'b0, inst_pc}, {20'b0, pc});
      chk({name, "_inst"}, {16'b0, inst}, {16'b0, romf(pc)});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst_n_w = 1'b0;
      halt = 1'b0; redirect = 1'b0; redirect_pc = 12'h000; inst_ready = 1'b1;
      repeat (2) @(posedge clk);
      #4;
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_rom_ready", {31'b0, rom_ready}, 32'd0);
      chk("rst_inst", {16'b0, inst}, 32'd0);
      chk("rst_inst_pc", {20'b0, inst_pc}, 32'd0);
      chk("rst_rom_addr", {20'b0, rom_addr}, 32'd0);

      // C0: first issue right after release
      nc(); rst_n = 1'b1; smp();
      chk("c0_rom_ready", {31'b0, rom_ready}, 32'd1);
      chk("c0_rom_addr", {20'b0, rom_addr}, 32'h000);
      chk("c0_valid", {31'b0, inst_valid}, 32'd0);
      nc(); smp();
      chk("c1_valid", {31'b0, inst_valid}, 32'd0);
      nc(); smp(); chk_head("c2", 12'h000);
      chk("c2_lit_inst", {16'b0, inst}, 32'h0100);
      nc(); smp(); chk_head("c3", 12'h001);
      chk("c3_lit_inst", {16'b0, inst}, 32'h0101);
      nc(); smp(); chk_head("c4", 12'h002);
      chk("c4_lit_inst", {16'b0, inst}, 32'h0102);

      // C5..C9: decoder stalls, queue fills, issue stops, head holds pc 3
      for (int i = 5; i <= 9; i++) begin
         nc(); inst_ready = 1'b0; smp();
         chk("stall_rom_ready", {31'b0, rom_ready}, 32'd0);
         chk_head("stall", 12'h003);
      end
      // C10: release, issue resumes the same cycle
      nc(); inst_ready = 1'b1; smp();
      chk("c10_rom_ready", {31'b0, rom_ready}, 32'd1);
      chk("c10_rom_addr", {20'b0, rom_addr}, 32'h005);
      chk_head("c10", 12'h003);
      nc(); smp(); chk_head("c11", 12'h004);
      nc(); smp(); chk_head("c12", 12'h005);
      nc(); smp(); chk_head("c13", 12'h006);
      nc(); smp();

      // C15: redirect to 0x040 with a read in flight and a pop coinciding
      nc(); redirect = 1'b1; redirect_pc = 12'h040; smp();
      chk("c15_rom_ready", {31'b0, rom_ready}, 32'd0);
      chk_head("c15", 12'h008);
      nc(); redirect = 1'b0; smp();
      chk("c16_valid", {31'b0, inst_valid}, 32'd0);
      chk("c16_rom_ready", {31'b0, rom_ready}, 32'd1);
      chk("c16_rom_addr", {20'b0, rom_addr}, 32'h040);
      nc(); smp();
      chk("c17_valid", {31'b0, inst_valid}, 32'd0);
      nc(); smp(); chk_head("c18", 12'h040);
      chk("c18_lit_inst", {16'b0, inst}, 32'h0140);
      nc(); smp(); chk_head("c19", 12'h041);

      // C20..C23: halt; the outstanding read still arrives
      nc(); halt = 1'b1; smp();
      chk("c20_rom_ready", {31'b0, rom_ready}, 32'd0);
      chk_head("c20", 12'h042);
      nc(); smp();
      chk("c21_rom_ready", {31'b0, rom_ready}, 32'd0);
      chk_head("c21", 12'h043);
      nc(); smp();
      chk("c22_rom_ready", {31'b0, rom_ready}, 32'd0);
      chk("c22_valid", {31'b0, inst_valid}, 32'd0);
      nc(); smp();
      chk("c23_valid", {31'b0, inst_valid}, 32'd0);
      nc(); halt = 1'b0; smp();
      chk("c24_rom_ready", {31'b0, rom_ready}, 32'd1);
      chk("c24_rom_addr", {20'b0, rom_addr}, 32'h044);
      chk("c24_valid", {31'b0, inst_valid}, 32'd0);
      nc(); smp();
      chk("c25_valid", {31'b0, inst_valid}, 32'd0);
      nc(); smp(); chk_head("c26", 12'h044);

      // C27..C30: halt with a redirect to 0x010 in the middle
      nc(); halt = 1'b1; smp();
      chk("c27_rom_ready", {31'b0, rom_ready}, 32'd0);
      chk_head("c27", 12'h045);
      nc(); redirect = 1'b1; redirect_pc = 12'h010; smp();
      chk_head("c28", 12'h046);
      nc(); redirect = 1'b0; smp();
      chk("c29_valid", {31'b0, inst_valid}, 32'd0);
      chk("c29_rom_ready", {31'b0, rom_ready}, 32'd0);
      chk("c29_rom_addr", {20'b0, rom_addr}, 32'h010);
      nc(); smp();
      chk("c30_valid", {31'b0, inst_valid}, 32'd0);
      nc(); halt = 1'b0; smp();
      chk("c31_rom_ready", {31'b0, rom_ready}, 32'd1);
      chk("c31_rom_addr", {20'b0, rom_addr}, 32'h010);
      nc(); smp();
      chk("c32_valid", {31'b0, inst_valid}, 32'd0);
      nc(); smp(); chk_head("c33", 12'h010);
      nc(); smp(); chk_head("c34", 12'h011);

      // C35..C37: fill the queue, then async reset mid-cycle
      nc(); inst_ready = 1'b0; smp();
      chk("c35_rom_ready", {31'b0, rom_ready}, 32'd0);
      chk_head("c35", 12'h012);
      nc(); smp();
      chk_head("c36", 12'h012);
      nc(); smp();
      chk_head("c37", 12'h012);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, inst_valid}, 32'd0);
      chk("arst_rom_ready", {31'b0, rom_ready}, 32'd0);
      chk("arst_inst_pc", {20'b0, inst_pc}, 32'd0);
      chk("arst_rom_addr", {20'b0, rom_addr}, 32'h000);
      nc(); inst_ready = 1'b1; smp();
      chk("arst_hold_rom_ready", {31'b0, rom_ready}, 32'd0);
      nc(); rst_n = 1'b1; smp();
      chk("d0_rom_ready", {31'b0, rom_ready}, 32'd1);
      chk("d0_rom_addr", {20'b0, rom_addr}, 32'h000);
      nc(); smp();
      chk("d1_valid", {31'b0, inst_valid}, 32'd0);
      nc(); smp(); chk_head("d2", 12'h000);
      nc(); smp(); chk_head("d3", 12'h001);

      // wrap instance: RESET_PC = 0xFFE
      nc(); rst_n_w = 1'b1; smp();
      chk("w0_rom_ready", {31'b0, w_rom_ready}, 32'd1);
      chk("w0_rom_addr", {20'b0, w_rom_addr}, 32'hFFE);
      nc(); smp();
      chk("w1_valid", {31'b0, w_inst_valid}, 32'd0);
      nc(); smp();
      chk("w2_valid", {31'b0, w_inst_valid}, 32'd1);
      chk("w2_pc", {20'b0, w_inst_pc}, 32'hFFE);
      chk("w2_inst", {16'b0, w_inst}, 32'h10FE);
      nc(); smp();
      chk("w3_pc", {20'b0, w_inst_pc}, 32'hFFF);
      chk("w3_inst", {16'b0, w_inst}, 32'h10FF);
      nc(); smp();
      chk("w4_pc", {20'b0, w_inst_pc}, 32'h000);
      chk("w4_inst", {16'b0, w_inst}, 32'h0100);
      nc(); smp();
      chk("w5_valid", {31'b0, w_inst_valid}, 32'd1);
      chk("w5_pc", {20'b0, w_inst_pc}, 32'h001);
      chk("w5_inst", {16'b0, w_inst}, 32'h0101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
